// File: rtl/aliens_io_responder.sv
// I/O-space responder behind the main-CPU IOCS: DIP/player reads, control and sound latches,
// sound-CPU IRQ handshake. Optional watchdog compiled in with `define IO_WATCHDOG_EN.
module aliens_io_responder #(
    parameter logic [23:0] WDOG_CYCLES = 24'd1_000_000,
    parameter logic [7:0]  WDOG_PULSE  = 8'd16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iocs_n,
    input  logic       rw,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] dsw1,
    input  logic [7:0] dsw2,
    input  logic [7:0] dsw3,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    output logic [1:0] coin_cnt,
    output logic [1:0] bank,
    output logic       rmrd,
    output logic [7:0] snd_cmd,
    output logic       snd_irq,
    input  logic       snd_ack,
    output logic       wdog_rst
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_COMMIT} state_e;

    state_e        state_q, state_d;
    logic          iocs_prev_q;
    logic [AW-1:0] addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [1:0]    coin_cnt_q, coin_cnt_d;
    logic [1:0]    bank_q, bank_d;
    logic          rmrd_q, rmrd_d;
    logic [DW-1:0] snd_cmd_q, snd_cmd_d;
    logic          snd_irq_q, snd_irq_d;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] rdata_c;
    logic          start_c;

    // Read mux on the live address; sampled into dout at the start of an access
    always_comb begin
        rdata_c = 8'hFF;
        case (addr)
            4'h0:    rdata_c = dsw3;
            4'h1:    rdata_c = p1;
            4'h2:    rdata_c = p2;
            4'h3:    rdata_c = dsw2;
            4'h4:    rdata_c = dsw1;
            4'h8:    rdata_c = {snd_irq_q, overrun_q, 6'b0};
            default: rdata_c = 8'hFF;
        endcase
    end

    // A new access starts on a sampled falling edge, or back-to-back straight out of COMMIT
    assign start_c = !iocs_n && ((state_q == ST_IDLE && iocs_prev_q) || state_q == ST_COMMIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        dout_d  = 8'hFF;
        case (state_q)
            ST_IDLE:   if (start_c) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (iocs_n) begin
                    state_d = ST_COMMIT;
                end else begin
                    dout_d = dout_q;
                    if (!rw_q) wdata_d = din;
                end
            end
            ST_COMMIT: state_d = start_c ? ST_ACTIVE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (start_c) begin
            addr_d  = addr;
            rw_d    = rw;
            wdata_d = din;
            dout_d  = rw ? rdata_c : 8'hFF;
        end
    end

    // Side effects land on the edge that ends COMMIT; a same-cycle ack loses to a latch write
    always_comb begin
        coin_cnt_d = coin_cnt_q;
        bank_d     = bank_q;
        rmrd_d     = rmrd_q;
        snd_cmd_d  = snd_cmd_q;
        snd_irq_d  = snd_ack ? 1'b0 : snd_irq_q;
        overrun_d  = overrun_q;
        if (state_q == ST_COMMIT) begin
            if (rw_q) begin
                if (addr_q == 4'h8) overrun_d = 1'b0;
            end else begin
                case (addr_q)
                    4'h8: begin
                        coin_cnt_d = wdata_q[1:0];
                        bank_d     = wdata_q[4:3];
                        rmrd_d     = wdata_q[5];
                    end
                    4'hC: begin
                        snd_cmd_d = wdata_q;
                        snd_irq_d = 1'b1;
                        if (snd_irq_q && !snd_ack) overrun_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            iocs_prev_q <= 1'b1;
            addr_q      <= '0;
            rw_q        <= 1'b1;
            wdata_q     <= '0;
            dout_q      <= 8'hFF;
            coin_cnt_q  <= '0;
            bank_q      <= '0;
            rmrd_q      <= 1'b0;
            snd_cmd_q   <= '0;
            snd_irq_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iocs_prev_q <= iocs_n;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            coin_cnt_q  <= coin_cnt_d;
            bank_q      <= bank_d;
            rmrd_q      <= rmrd_d;
            snd_cmd_q   <= snd_cmd_d;
            snd_irq_q   <= snd_irq_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dout     = dout_q;
    assign coin_cnt = coin_cnt_q;
    assign bank     = bank_q;
    assign rmrd     = rmrd_q;
    assign snd_cmd  = snd_cmd_q;
    assign snd_irq  = snd_irq_q;

`ifdef IO_WATCHDOG_EN
    logic [23:0] wdog_cnt_q, wdog_cnt_d;
    logic [7:0]  pulse_cnt_q, pulse_cnt_d;
    logic        wdog_rst_q, wdog_rst_d;
    logic        kick_c;

    assign kick_c = (state_q == ST_COMMIT) && !rw_q && (addr_q == 4'h9);

    // Counter is held at zero while the pulse runs, then restarts
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q + 24'd1;
        pulse_cnt_d = pulse_cnt_q;
        if (pulse_cnt_q != 8'd0) begin
            pulse_cnt_d = pulse_cnt_q - 8'd1;
            wdog_cnt_d  = '0;
        end else if (wdog_cnt_q == WDOG_CYCLES - 24'd1) begin
            pulse_cnt_d = WDOG_PULSE;
            wdog_cnt_d  = '0;
        end
        if (kick_c) wdog_cnt_d = '0;
        wdog_rst_d = (pulse_cnt_d != 8'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            wdog_rst_q  <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            wdog_rst_q  <= wdog_rst_d;
        end
    end

    assign wdog_rst = wdog_rst_q;
`else
    logic unused_wdog_params;
    assign unused_wdog_params = ^{WDOG_CYCLES, WDOG_PULSE};
    assign wdog_rst = 1'b0;
`endif

endmodule

// File: tb/tb_aliens_io_responder.sv
// Directed self-checking bench for aliens_io_responder.
module tb_aliens_io_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       iocs_n = 1'b1;
    logic       rw = 1'b1;
    logic [3:0] addr = 4'h0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] dsw1 = 8'h5A;
    logic [7:0] dsw2 = 8'hC3;
    logic [7:0] dsw3 = 8'h3C;
    logic [7:0] p1 = 8'hFE;
    logic [7:0] p2 = 8'hE7;
    logic [1:0] coin_cnt;
    logic [1:0] bank;
    logic       rmrd;
    logic [7:0] snd_cmd;
    logic       snd_irq;
    logic       snd_ack = 1'b0;
    logic       wdog_rst;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    aliens_io_responder #(.WDOG_CYCLES(24'd100), .WDOG_PULSE(8'd4)) dut (
        .clk(clk), .reset_n(reset_n), .iocs_n(iocs_n), .rw(rw), .addr(addr), .din(din),
        .dout(dout), .dsw1(dsw1), .dsw2(dsw2), .dsw3(dsw3), .p1(p1), .p2(p2),
        .coin_cnt(coin_cnt), .bank(bank), .rmrd(rmrd), .snd_cmd(snd_cmd),
        .snd_irq(snd_irq), .snd_ack(snd_ack), .wdog_rst(wdog_rst)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        iocs_n  = 1'b1;
        rw      = 1'b1;
        snd_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Full access; rd is dout one cycle after iocs_n falls; returns once side effects are visible
    task automatic do_access(input logic r, input logic [3:0] a, input logic [7:0] d,
                             input int hold, output logic [7:0] rd);
        @(negedge clk);
        iocs_n = 1'b0; rw = r; addr = a; din = d;
        @(posedge clk); #1;
        rd = dout;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        iocs_n = 1'b1; rw = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk); #1;
        total++; if (dout !== 8'hFF) $display("FAIL reset_dout got %h exp ff", dout); else passed++;
        total++; if ({coin_cnt, bank, rmrd} !== 5'b0) $display("FAIL reset_ctrl got %b exp 00000", {coin_cnt, bank, rmrd}); else passed++;
        total++; if (snd_cmd !== 8'h00 || snd_irq !== 1'b0) $display("FAIL reset_snd got %h/%b exp 00/0", snd_cmd, snd_irq); else passed++;
        total++; if (wdog_rst !== 1'b0) $display("FAIL reset_wdog got %b exp 0", wdog_rst); else passed++;
    endtask

    task automatic test_reads();
        logic [7:0] rd;
        logic [3:0] addrs [6] = '{4'h4, 4'h1, 4'h7, 4'h0, 4'h3, 4'h2};
        logic [7:0] exps  [6] = '{8'h5A, 8'hFE, 8'hFF, 8'h3C, 8'hC3, 8'hE7};
        for (int i = 0; i < 6; i++) begin
            do_access(1'b1, addrs[i], 8'h00, 1, rd);
            total++;
            if (rd !== exps[i]) $display("FAIL read_addr%0h got %h exp %h", addrs[i], rd, exps[i]);
            else passed++;
        end
        total++; if (dout !== 8'hFF) $display("FAIL idle_dout got %h exp ff", dout); else passed++;
    endtask

    task automatic test_control();
        @(negedge clk);
        iocs_n = 1'b0; rw = 1'b0; addr = 4'h8; din = 8'h3B;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({coin_cnt, bank, rmrd} !== 5'b0) $display("FAIL ctrl_early got %b exp 00000", {coin_cnt, bank, rmrd}); else passed++;
        @(negedge clk);
        iocs_n = 1'b1; rw = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (coin_cnt !== 2'b11) $display("FAIL ctrl_coin got %b exp 11", coin_cnt); else passed++;
        total++; if (bank !== 2'b11) $display("FAIL ctrl_bank got %b exp 11", bank); else passed++;
        total++; if (rmrd !== 1'b1) $display("FAIL ctrl_rmrd got %b exp 1", rmrd); else passed++;
    endtask

    task automatic test_sound();
        logic [7:0] rd;
        do_access(1'b0, 4'hC, 8'h42, 1, rd);
        total++; if (snd_cmd !== 8'h42) $display("FAIL snd_cmd got %h exp 42", snd_cmd); else passed++;
        total++; if (snd_irq !== 1'b1) $display("FAIL snd_irq_set got %b exp 1", snd_irq); else passed++;
        @(negedge clk); snd_ack = 1'b1;
        @(posedge clk); #1;
        total++; if (snd_irq !== 1'b0) $display("FAIL snd_ack_clear got %b exp 0", snd_irq); else passed++;
        @(negedge clk); snd_ack = 1'b0;
        do_access(1'b1, 4'h8, 8'h00, 1, rd);
        total++; if (rd !== 8'h00) $display("FAIL status_clean got %h exp 00", rd); else passed++;
    endtask

    task automatic test_overrun();
        logic [7:0] rd;
        do_access(1'b0, 4'hC, 8'h01, 1, rd);
        do_access(1'b0, 4'hC, 8'h02, 2, rd);
        total++; if (snd_cmd !== 8'h02) $display("FAIL ovr_cmd got %h exp 02", snd_cmd); else passed++;
        do_access(1'b1, 4'h8, 8'h00, 1, rd);
        total++; if (rd !== 8'hC0) $display("FAIL ovr_status1 got %h exp c0", rd); else passed++;
        do_access(1'b1, 4'h8, 8'h00, 1, rd);
        total++; if (rd !== 8'h80) $display("FAIL ovr_status2 got %h exp 80", rd); else passed++;
        // Third write with the ack landing in its COMMIT cycle
        @(negedge clk);
        iocs_n = 1'b0; rw = 1'b0; addr = 4'hC; din = 8'h03;
        @(posedge clk);
        @(negedge clk);
        iocs_n = 1'b1; rw = 1'b1;
        @(posedge clk);
        @(negedge clk); snd_ack = 1'b1;
        @(posedge clk); #1;
        total++; if (snd_irq !== 1'b1 || snd_cmd !== 8'h03) $display("FAIL collide_irq got %b/%h exp 1/03", snd_irq, snd_cmd); else passed++;
        @(negedge clk); snd_ack = 1'b0;
        do_access(1'b1, 4'h8, 8'h00, 1, rd);
        total++; if (rd !== 8'h80) $display("FAIL collide_status got %h exp 80", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        // Write latch, then re-select directly out of COMMIT for a read of p2
        @(negedge clk);
        iocs_n = 1'b0; rw = 1'b0; addr = 4'hC; din = 8'h77;
        @(posedge clk);
        @(negedge clk);
        iocs_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iocs_n = 1'b0; rw = 1'b1; addr = 4'h2;
        @(posedge clk); #1;
        rd = dout;
        total++; if (rd !== 8'hE7) $display("FAIL b2b_read got %h exp e7", rd); else passed++;
        total++; if (snd_cmd !== 8'h77) $display("FAIL b2b_cmd got %h exp 77", snd_cmd); else passed++;
        @(negedge clk);
        iocs_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] rd;
        apply_reset();
        @(negedge clk);
        iocs_n = 1'b0; rw = 1'b0; addr = 4'hC; din = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1 iocs_n = 1'b1; rw = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (snd_cmd !== 8'h00) $display("FAIL midrst_cmd got %h exp 00", snd_cmd); else passed++;
        total++; if (snd_irq !== 1'b0) $display("FAIL midrst_irq got %b exp 0", snd_irq); else passed++;
        total++; if (dout !== 8'hFF) $display("FAIL midrst_dout got %h exp ff", dout); else passed++;
        do_access(1'b1, 4'h4, 8'h00, 1, rd);
        total++; if (rd !== 8'h5A) $display("FAIL midrst_read got %h exp 5a", rd); else passed++;
    endtask

    task automatic test_watchdog();
        int first = 0;
        int high  = 0;
        logic [7:0] rd;
        apply_reset();
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); #1;
            if (wdog_rst === 1'b1) begin
                if (first == 0) first = c;
                high++;
            end
        end
`ifdef IO_WATCHDOG_EN
        total++; if (first !== 100) $display("FAIL wdog_first got %0d exp 100", first); else passed++;
        total++; if (high !== 4) $display("FAIL wdog_width got %0d exp 4", high); else passed++;
        apply_reset();
        high = 0;
        for (int k = 0; k < 6; k++) begin
            do_access(1'b0, 4'h9, 8'h00, 1, rd);
            if (wdog_rst === 1'b1) high++;
            for (int c = 0; c < 46; c++) begin
                @(posedge clk); #1;
                if (wdog_rst === 1'b1) high++;
            end
        end
        total++; if (high !== 0) $display("FAIL wdog_kicked got %0d exp 0", high); else passed++;
`else
        total++; if (high !== 0) $display("FAIL wdog_disabled got %0d exp 0", high); else passed++;
        do_access(1'b0, 4'h9, 8'h00, 1, rd);
        total++; if ({coin_cnt, bank, rmrd, snd_cmd, snd_irq} !== 14'b0) $display("FAIL wdog_kick_noop got %b exp 0", {coin_cnt, bank, rmrd, snd_cmd, snd_irq}); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_reads();
        test_control();
        test_sound();
        test_overrun();
        test_back_to_back();
        test_reset_mid_access();
        test_watchdog();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aliens_io_responder.md
Name: aliens_io_responder

Overview:
- Synchronous responder behind the main-CPU I/O chip select (IOCS, active low) produced by the address-decode PAL.
- Serves CPU reads of DIP switches and player inputs.
- Latches CPU writes to the control register (coin counters, bank, RMRD) and the sound-command latch.
- Runs the main→sound CPU command handshake (IRQ set on write, cleared by sound-side ack) and an optional watchdog.

Parameters:
- WDOG_CYCLES, 24'd1_000_000, clk cycles without a kick before the watchdog fires.
- WDOG_PULSE, 8'd16, width in clk cycles of the wdog_rst pulse.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- iocs_n  in  1  I/O chip select from the decoder, active low, already synchronous to clk.
- rw  in  1  CPU R/W: 1=read, 0=write.
- addr  in  4  CPU address bits [3:0].
- din  in  8  CPU write data.
- dout  out  8  CPU read data.
- dsw1, dsw2, dsw3  in  8 each  DIP switch banks.
- p1, p2  in  8 each  player inputs, active low.
- coin_cnt  out  2  coin counter drives.
- bank  out  2  ROM bank select.
- rmrd  out  1  tile-ROM read-mode select, fed back to the decoder.
- snd_cmd  out  8  sound command latch.
- snd_irq  out  1  IRQ to the sound CPU, active high.
- snd_ack  in  1  sound CPU acknowledge; a single-cycle pulse.
- wdog_rst  out  1  watchdog reset request, active high.

Behaviour:
- Reset (async, reset_n=0): dout=8'hFF, coin_cnt=0, bank=0, rmrd=0, snd_cmd=0, snd_irq=0, overrun=0, wdog_rst=0, watchdog counter=0. Reset mid-access abandons the access; no write commits.
- Access FSM states: IDLE, ACTIVE, COMMIT.
  - IDLE→ACTIVE: iocs_n sampled 0 while the previous sample was 1. Capture addr and rw.
  - ACTIVE: each cycle, capture din when rw=0.
  - ACTIVE→COMMIT: iocs_n sampled 1.
  - COMMIT performs the write side effect (rw=0 only) for one cycle, then returns to IDLE. If iocs_n is low again in COMMIT, the FSM enters ACTIVE directly and treats it as a new access.
- Read latency: dout is valid 1 cycle after the iocs_n falling edge. It holds while in ACTIVE and returns to 8'hFF in IDLE.
- Read map (addr):
  - 0: dsw3
  - 1: p1
  - 2: p2
  - 3: dsw2
  - 4: dsw1
  - 8: status {snd_irq, overrun, 6'b0}
  - any other address: 8'hFF
- Reading status clears overrun, at COMMIT of that read.
- Write map (addr):
  - 8: control. din[1:0]→coin_cnt, din[4:3]→bank, din[5]→rmrd; other bits ignored.
  - 9: watchdog kick; data ignored.
  - C: sound latch. din→snd_cmd; snd_irq←1. If snd_irq was already 1, overrun←1.
  - Other addresses: no effect.
- snd_ack clears snd_irq on the next edge.
- snd_ack in the same cycle as a sound-latch COMMIT: the COMMIT wins, snd_irq stays 1, overrun is not set.
- Outputs are registered; no combinational path from iocs_n to any output.
- Watchdog (only when compiled in):
  - 24-bit counter increments every cycle and clears on a kick COMMIT.
  - When the counter reaches WDOG_CYCLES-1: wdog_rst=1 for WDOG_PULSE cycles, then the counter restarts from 0.
  - A kick during the pulse clears the counter but does not shorten the pulse.
  - The block's own registers are not reset by wdog_rst.

Optional Feature:
- Macro IO_WATCHDOG_EN.
- Defined: the watchdog operates as above.
- Undefined: no counter logic; wdog_rst is tied 0; a write to addr 9 is a no-op.

Test Plan:
- Reset and reads: reset with dsw1=8'h5A, p1=8'hFE. Read addr 4 → dout=8'h5A one cycle after iocs_n falls. Read addr 1 → 8'hFE. Read addr 7 → 8'hFF. dout=8'hFF when idle.
- Control write: write 8'h3B to addr 8 → after iocs_n rises, coin_cnt=2'b11, bank=2'b11, rmrd=1; no change while iocs_n is still low.
- Sound handshake: write 8'h42 to addr C → snd_cmd=8'h42 and snd_irq=1 on the COMMIT cycle. Pulse snd_ack → snd_irq=0 the next cycle. Read status → 8'h00.
- Overrun and collision: write 8'h01 then 8'h02 to addr C without ack → snd_cmd=8'h02, status read=8'hC0, a second status read=8'h80. Ack coincident with a third write → snd_irq stays 1.
- Watchdog (IO_WATCHDOG_EN, WDOG_CYCLES=100, WDOG_PULSE=4):
  - No kicks → wdog_rst=1 for exactly 4 cycles, first asserted 100 cycles after reset release.
  - Kick every 50 cycles → wdog_rst never asserts.
  - Without the macro → wdog_rst stays 0.
- Reset mid-access: assert reset_n=0 during an ACTIVE write to addr C → snd_cmd stays 0, snd_irq stays 0, and the FSM is in IDLE after release.
